// File: rtl/multicycle_controller_pkg.sv
// riscv_ctrl_pkg: opcodes, ALU/mux encodings and FSM states shared by the multicycle controller.
package riscv_ctrl_pkg;
  localparam logic [6:0] ALU_R     = 7'b0110011;
  localparam logic [6:0] ALU_I     = 7'b0010011;
  localparam logic [6:0] BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] JUMP      = 7'b1101111;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [1:0] ADD_OPCODE    = 2'b00;
  localparam logic [1:0] SUB_OPCODE    = 2'b01;
  localparam logic [1:0] R_TYPE_OPCODE = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: IR/flag inputs and datapath control outputs of the sequencer.
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic enable, zero, mem_ready;
  logic [6:0] opcode;
  logic mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic reg_write, mem_2_reg, instr_done, trap;
  logic [1:0] trap_cause;
  logic [CNT_W-1:0] retired;
  modport master (
    input enable, opcode, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
    alu_src_b, alu_op, reg_write, mem_2_reg, instr_done, trap, trap_cause, retired
  );
  modport slave (
    output enable, opcode, zero, mem_ready,
    input mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
    alu_src_b, alu_op, reg_write, mem_2_reg, instr_done, trap, trap_cause, retired
  );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles; timeout once MEM_TIMEOUT waits have elapsed.
module mem_wait_timer #(parameter int MEM_TIMEOUT = 15) (
  input  logic clk,
  input  logic arst_n,
  input  logic wait_cyc,
  output logic timeout
);
  logic [7:0] cnt;
  assign timeout = cnt == 8'(MEM_TIMEOUT);
  // Any non-waiting cycle clears, so every memory state is entered with a zero count.
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) cnt <= '0;
    else cnt <= (wait_cyc && !timeout) ? cnt + 8'd1 : '0;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory timeout and illegal-opcode trap.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic arst_n,
  multicycle_controller_if.master bus
);
  state_t st, ns, nxt;
  logic timeout, wait_cyc, trap_q;
  logic [1:0] cause_q;
  logic [CNT_W-1:0] ret_q;
  assign wait_cyc = (st == S_FETCH || st == S_MEM_RD || st == S_MEM_WR) && !bus.mem_ready;
  assign nxt = bus.enable ? S_FETCH : S_IDLE;
  assign bus.trap = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.retired = ret_q;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .arst_n(arst_n), .wait_cyc(wait_cyc), .timeout(timeout)
  );
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      st <= S_IDLE;
      trap_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      ret_q <= '0;
    end else begin
      st <= ns;
      if (ns == S_TRAP && st != S_TRAP) begin
        trap_q <= 1'b1;
        cause_q <= st == S_DECODE ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end
      if (bus.instr_done) ret_q <= ret_q + 1'b1;
    end
  always_comb begin
    ns = st;
    case (st)
      S_IDLE:     ns = nxt;
      S_FETCH:    ns = bus.mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE:   ns = bus.opcode == ALU_R ? S_EXEC_R :
                       bus.opcode == ALU_I ? S_EXEC_I :
                       (bus.opcode == LOAD || bus.opcode == STORE) ? S_MEM_ADDR :
                       bus.opcode == BRANCH_EQ ? S_BRANCH :
                       bus.opcode == JUMP ? S_JUMP : S_TRAP;
      S_EXEC_R,
      S_EXEC_I:   ns = S_WB_ALU;
      S_MEM_ADDR: ns = bus.opcode == STORE ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   ns = bus.mem_ready ? S_WB_MEM : timeout ? S_TRAP : S_MEM_RD;
      S_MEM_WR:   ns = bus.mem_ready ? nxt : timeout ? S_TRAP : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: ns = nxt;
      default:    ns = S_TRAP;
    endcase
  end
  always_comb begin
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_or_d = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = SRC_B_RS2;
    bus.alu_op = ADD_OPCODE;
    bus.reg_write = 1'b0;
    bus.mem_2_reg = 1'b0;
    bus.instr_done = 1'b0;
    case (st)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.alu_src_b = SRC_B_FOUR;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = SRC_B_IMM;
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = R_TYPE_OPCODE;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write = 1'b1;
        bus.mem_2_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = SUB_OPCODE;
        bus.pc_src = 1'b1;
        bus.pc_write = bus.zero;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction streams checked cycle-by-cycle against a phase-level model.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;
  localparam int TO = 15;
  typedef struct packed {
    logic mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic reg_write, mem_2_reg, instr_done, trap;
    logic [1:0] trap_cause;
  } ctl_t;
  typedef struct packed {
    ctl_t c;
    logic [3:0] r;
  } exp_t;
  logic clk = 1'b0, arst_n = 1'b0;
  exp_t q[$];
  int checks = 0, passed = 0;
  logic [3:0] ret_m = '0;
  always #5 clk = ~clk;
  multicycle_controller_if #(.CNT_W(4)) bus ();
  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

  function automatic ctl_t got();
    ctl_t c;
    c.mem_read = bus.mem_read;
    c.mem_write = bus.mem_write;
    c.i_or_d = bus.i_or_d;
    c.ir_write = bus.ir_write;
    c.pc_write = bus.pc_write;
    c.pc_src = bus.pc_src;
    c.alu_src_a = bus.alu_src_a;
    c.alu_src_b = bus.alu_src_b;
    c.alu_op = bus.alu_op;
    c.reg_write = bus.reg_write;
    c.mem_2_reg = bus.mem_2_reg;
    c.instr_done = bus.instr_done;
    c.trap = bus.trap;
    c.trap_cause = bus.trap_cause;
    return c;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("controls", 32'(got()), 32'(e.c));
      chk("retired", 32'(bus.retired), 32'(e.r));
    end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(logic rdy, logic z, logic en, ctl_t c);
    exp_t e;
    @(posedge clk);
    #1;
    bus.enable = en;
    bus.mem_ready = rdy;
    bus.zero = z;
    e.c = c;
    e.r = ret_m;
    q.push_back(e);
    if (c.instr_done) ret_m++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    arst_n = 1'b0;
    bus.enable = 1'b0;
    #1;
    chk("reset_ctl", 32'(got()), 32'd0);
    chk("reset_retired", 32'(bus.retired), 32'd0);
    ret_m = '0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    cyc(rb(), rb(), 1'b0, '0);
    cyc(rb(), rb(), 1'b1, '0);
  endtask

  task automatic trap_out(logic [1:0] cause);
    ctl_t c;
    c = '0;
    c.trap = 1'b1;
    c.trap_cause = cause;
    repeat (4) cyc(rb(), rb(), rb(), c);
    do_reset();
  endtask

  // Memory phase: w wait cycles then the ready cycle; w > TO means ready never comes.
  task automatic mem_phase(ctl_t c, ctl_t fin, int w, output logic tr);
    tr = 1'b0;
    for (int i = 0; i < w && i <= TO; i++) cyc(1'b0, rb(), rb(), c);
    if (w > TO) tr = 1'b1;
    else cyc(1'b1, rb(), fin.instr_done ? 1'b1 : rb(), fin);
  endtask

  task automatic instr(logic [6:0] op, int fw, int mw, logic z);
    ctl_t c, f;
    logic tr;
    bus.opcode = op;
    c = '0;
    c.mem_read = 1'b1;
    c.alu_src_b = 2'b01;
    f = c;
    f.ir_write = 1'b1;
    f.pc_write = 1'b1;
    mem_phase(c, f, fw, tr);
    if (tr) begin
      trap_out(2'b10);
      return;
    end
    c = '0;
    c.alu_src_b = 2'b10;
    cyc(rb(), rb(), rb(), c);
    c = '0;
    f = '0;
    f.reg_write = 1'b1;
    f.instr_done = 1'b1;
    if (op == ALU_R || op == ALU_I) begin
      c.alu_src_a = 1'b1;
      c.alu_src_b = op == ALU_I ? 2'b10 : 2'b00;
      c.alu_op = op == ALU_R ? 2'b10 : 2'b00;
      cyc(rb(), rb(), rb(), c);
      cyc(rb(), rb(), 1'b1, f);
    end else if (op == LOAD || op == STORE) begin
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      cyc(rb(), rb(), rb(), c);
      c = '0;
      c.i_or_d = 1'b1;
      c.mem_read = op == LOAD;
      c.mem_write = op == STORE;
      f = c;
      f.instr_done = op == STORE;
      mem_phase(c, f, mw, tr);
      if (tr) begin
        trap_out(2'b10);
        return;
      end
      c = '0;
      c.reg_write = 1'b1;
      c.mem_2_reg = 1'b1;
      c.instr_done = 1'b1;
      if (op == LOAD) cyc(rb(), rb(), 1'b1, c);
    end else if (op == BRANCH_EQ || op == JUMP) begin
      c.pc_src = 1'b1;
      c.instr_done = 1'b1;
      c.pc_write = op == JUMP ? 1'b1 : z;
      c.alu_src_a = op == BRANCH_EQ;
      c.alu_op = op == BRANCH_EQ ? 2'b01 : 2'b00;
      cyc(rb(), z, 1'b1, c);
    end else trap_out(2'b01);
  endtask

  function automatic int rw();
    return $urandom_range(0, 7) == 0 ? TO : int'($urandom_range(0, 3));
  endfunction

  logic [6:0] ops[6];
  initial begin
    ctl_t c;
    ops[0] = ALU_R; ops[1] = ALU_I; ops[2] = LOAD;
    ops[3] = STORE; ops[4] = BRANCH_EQ; ops[5] = JUMP;
    bus.enable = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    bus.opcode = '0;
    #3;
    chk("por_ctl", 32'(got()), 32'd0);
    chk("por_retired", 32'(bus.retired), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, '0);
    instr(ALU_R, 0, 0, 1'b0);
    instr(LOAD, 0, 3, 1'b0);
    instr(BRANCH_EQ, 0, 0, 1'b1);
    instr(BRANCH_EQ, 0, 0, 1'b0);
    instr(JUMP, 1, 0, 1'b0);
    instr(ALU_I, 2, 0, 1'b0);
    instr(STORE, 0, 0, 1'b0);
    instr(STORE, TO, TO, 1'b0);
    instr(LOAD, TO, TO, 1'b0);
    for (int i = 0; i < 40; i++) instr(ops[$urandom_range(0, 5)], rw(), rw(), rb());
    instr(7'b1111111, 0, 0, 1'b0);
    instr(ALU_R, TO + 1, 0, 1'b0);
    instr(LOAD, 0, TO + 1, 1'b0);
    instr(STORE, 1, TO + 1, 1'b0);
    bus.opcode = STORE;
    c = '0;
    c.mem_read = 1'b1;
    c.alu_src_b = 2'b01;
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, c);
    c = '0;
    c.alu_src_b = 2'b10;
    cyc(1'b0, 1'b0, 1'b1, c);
    c.alu_src_a = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, c);
    c = '0;
    c.mem_write = 1'b1;
    c.i_or_d = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, c);
    cyc(1'b0, 1'b0, 1'b1, c);
    do_reset();
    for (int i = 0; i < 20; i++) instr(ops[$urandom_range(0, 5)], rw(), rw(), rb());
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
